c2f_chunk_consumer: RTL and testbench

- FPGA-side consumer of the CPU->FPGA (C2F) circular chunk buffer.
- Host burst-writes QWs into the chunk RAM via C2F_BAR, then advances the write pointer through the C2F_WRPTR register.
- Block streams each complete chunk out as a 64-bit valid/ready stream and advances its read pointer.
- Block requests a metrics DMA so the read pointer lands in host memory at C2F_RDPTR_ADDR.

---
 rtl/c2f_chunk_consumer.sv | 229 ++++++++++++++++++++++
 tb/tb_c2f_chunk_consumer.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/c2f_chunk_consumer.sv
// C2F chunk-ring consumer: streams each published chunk out of the chunk RAM
// as 64-bit valid/ready beats and reports the read pointer via a metrics DMA.
module c2f_chunk_consumer #(
    parameter int CHUNK_BYTES = 512,
    parameter int NUM_CHUNKS  = 4,
    localparam int QWS        = CHUNK_BYTES / 8,
    localparam int PTR_W      = $clog2(NUM_CHUNKS),
    localparam int QW_W       = $clog2(QWS),
    localparam int ADDR_W     = PTR_W + QW_W
) (
    input  logic              clk_in,
    input  logic              rstn,
    input  logic              ramWrEnable_in,
    input  logic [ADDR_W-1:0] ramWrAddr_in,
    input  logic [63:0]       ramWrData_in,
    input  logic              wrPtrValid_in,
    input  logic [PTR_W-1:0]  wrPtr_in,
    input  logic              softReset_in,
    output logic [63:0]       c2fData_out,
    output logic              c2fValid_out,
    input  logic              c2fReady_in,
    output logic [PTR_W-1:0]  rdPtr_out,
    output logic              mtrReq_out,
    output logic [31:0]       mtrData_out,
    input  logic              mtrAck_in
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DRAIN
    } stream_state_t;

    typedef enum logic {
        M_IDLE,
        M_REQ
    } mtr_state_t;

    logic [63:0]       r_mem [NUM_CHUNKS*QWS];
    logic [63:0]       r_rdData;
    logic              r_rdPend;

    stream_state_t     r_state;
    logic [PTR_W-1:0]  r_wrPtr;
    logic [PTR_W-1:0]  r_rdPtr;
    logic [QW_W-1:0]   r_qwIdx;
    logic [QW_W-1:0]   r_accIdx;

    logic [63:0]       r_fifo [2];
    logic              r_head;
    logic              r_tail;
    logic [1:0]        r_cnt;

    mtr_state_t        r_mtrState;
    logic              r_mtrReq;
    logic [31:0]       r_mtrData;
    logic [PTR_W-1:0]  r_mtrSent;
    logic              r_mtrClr;

    logic              w_valid;
    logic              w_pop;
    logic [1:0]        w_occ;
    logic              w_space;
    logic              w_empty;
    logic              w_rdIssue;
    logic [ADDR_W-1:0] w_rdAddr;
    logic              w_lastAcc;
    logic [PTR_W-1:0]  w_wrPtrNext;
    logic [PTR_W-1:0]  w_rdPtrInc;
    logic [PTR_W-1:0]  w_mtrVal;

    // Chunk RAM: passive write port, 1-cycle synchronous read port.
    always_ff @(posedge clk_in) begin
        if (ramWrEnable_in) begin
            r_mem[ramWrAddr_in] <= ramWrData_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (w_rdIssue) begin
            r_rdData <= r_mem[w_rdAddr];
        end
    end

    // A read may issue when the FIFO plus the read in flight, less the beat
    // leaving this cycle, still leaves room; this sustains one beat per cycle.
    always_comb begin
        w_valid     = (r_cnt != 2'd0);
        w_pop       = w_valid & c2fReady_in;
        w_occ       = r_cnt + {1'b0, r_rdPend} - {1'b0, w_pop};
        w_space     = ~w_occ[1];
        w_empty     = (r_rdPtr == r_wrPtr);
        w_rdAddr    = {r_rdPtr, r_qwIdx};
        w_wrPtrNext = wrPtrValid_in ? wrPtr_in : r_wrPtr;
        w_rdPtrInc  = r_rdPtr + PTR_W'(1);
        w_lastAcc   = (r_state == S_DRAIN) & w_pop & (r_accIdx == QW_W'(QWS - 1));
        w_rdIssue   = 1'b0;
        if (!softReset_in) begin
            case (r_state)
                S_IDLE:   w_rdIssue = ~w_empty & w_space;
                S_STREAM: w_rdIssue = w_space;
                default:  w_rdIssue = 1'b0;
            endcase
        end
    end

    // IDLE issues QW0 itself on leaving, so the first beat is not delayed.
    always_ff @(posedge clk_in or negedge rstn) begin
        if (!rstn) begin
            r_state  <= S_IDLE;
            r_wrPtr  <= '0;
            r_rdPtr  <= '0;
            r_qwIdx  <= '0;
            r_accIdx <= '0;
            r_rdPend <= 1'b0;
            r_head   <= 1'b0;
            r_tail   <= 1'b0;
            r_cnt    <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                r_fifo[i] <= '0;
            end
        end else if (softReset_in) begin
            r_state  <= S_IDLE;
            r_wrPtr  <= '0;
            r_rdPtr  <= '0;
            r_qwIdx  <= '0;
            r_accIdx <= '0;
            r_rdPend <= 1'b0;
            r_head   <= 1'b0;
            r_tail   <= 1'b0;
            r_cnt    <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                r_fifo[i] <= '0;
            end
        end else begin
            if (wrPtrValid_in) begin
                r_wrPtr <= wrPtr_in;
            end

            r_rdPend <= w_rdIssue;
            if (r_rdPend) begin
                r_fifo[r_tail] <= r_rdData;
                r_tail         <= ~r_tail;
            end
            if (w_pop) begin
                r_head   <= ~r_head;
                r_accIdx <= r_accIdx + QW_W'(1);
            end
            r_cnt <= r_cnt + {1'b0, r_rdPend} - {1'b0, w_pop};

            case (r_state)
                S_IDLE: begin
                    if (w_rdIssue) begin
                        r_qwIdx <= r_qwIdx + QW_W'(1);
                        r_state <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (w_rdIssue) begin
                        r_qwIdx <= r_qwIdx + QW_W'(1);
                        if (r_qwIdx == QW_W'(QWS - 1)) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_lastAcc) begin
                        r_rdPtr <= w_rdPtrInc;
                        r_state <= (w_rdPtrInc != w_wrPtrNext) ? S_STREAM : S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_mtrVal = r_mtrData[PTR_W-1:0];

    // A soft reset during a pending request lets it complete, then forgets it.
    always_ff @(posedge clk_in or negedge rstn) begin
        if (!rstn) begin
            r_mtrState <= M_IDLE;
            r_mtrReq   <= 1'b0;
            r_mtrData  <= '0;
            r_mtrSent  <= '0;
            r_mtrClr   <= 1'b0;
        end else begin
            case (r_mtrState)
                M_IDLE: begin
                    if (softReset_in) begin
                        r_mtrSent <= '0;
                    end else if (r_rdPtr != r_mtrSent) begin
                        r_mtrReq   <= 1'b1;
                        r_mtrData  <= {{(32-PTR_W){1'b0}}, r_rdPtr};
                        r_mtrState <= M_REQ;
                    end
                end
                M_REQ: begin
                    if (mtrAck_in) begin
                        r_mtrClr <= 1'b0;
                        if (softReset_in || r_mtrClr) begin
                            r_mtrSent  <= '0;
                            r_mtrReq   <= 1'b0;
                            r_mtrState <= M_IDLE;
                        end else begin
                            r_mtrSent <= w_mtrVal;
                            if (r_rdPtr != w_mtrVal) begin
                                r_mtrData <= {{(32-PTR_W){1'b0}}, r_rdPtr};
                            end else begin
                                r_mtrReq   <= 1'b0;
                                r_mtrState <= M_IDLE;
                            end
                        end
                    end else if (softReset_in) begin
                        r_mtrClr <= 1'b1;
                    end
                end
                default: r_mtrState <= M_IDLE;
            endcase
        end
    end

    assign c2fValid_out = w_valid;
    assign c2fData_out  = r_fifo[r_head];
    assign rdPtr_out    = r_rdPtr;
    assign mtrReq_out   = r_mtrReq;
    assign mtrData_out  = r_mtrData;

endmodule

// File: tb/tb_c2f_chunk_consumer.sv
// Randomised bench for c2f_chunk_consumer: a queue/array model of the chunk
// ring predicts every accepted beat, the read pointer and the metrics requests.
module tb_c2f_chunk_consumer;

    localparam int CB    = 512;
    localparam int NC    = 4;
    localparam int QWS   = CB / 8;
    localparam int PTR_W = 2;
    localparam int AW    = 8;

    logic              clk_in = 1'b0;
    logic              rstn;
    logic              ramWrEnable_in;
    logic [AW-1:0]     ramWrAddr_in;
    logic [63:0]       ramWrData_in;
    logic              wrPtrValid_in;
    logic [PTR_W-1:0]  wrPtr_in;
    logic              softReset_in;
    logic [63:0]       c2fData_out;
    logic              c2fValid_out;
    logic              c2fReady_in;
    logic [PTR_W-1:0]  rdPtr_out;
    logic              mtrReq_out;
    logic [31:0]       mtrData_out;
    logic              mtrAck_in;

    c2f_chunk_consumer #(.CHUNK_BYTES(CB), .NUM_CHUNKS(NC)) dut (
        .clk_in        (clk_in),
        .rstn          (rstn),
        .ramWrEnable_in(ramWrEnable_in),
        .ramWrAddr_in  (ramWrAddr_in),
        .ramWrData_in  (ramWrData_in),
        .wrPtrValid_in (wrPtrValid_in),
        .wrPtr_in      (wrPtr_in),
        .softReset_in  (softReset_in),
        .c2fData_out   (c2fData_out),
        .c2fValid_out  (c2fValid_out),
        .c2fReady_in   (c2fReady_in),
        .rdPtr_out     (rdPtr_out),
        .mtrReq_out    (mtrReq_out),
        .mtrData_out   (mtrData_out),
        .mtrAck_in     (mtrAck_in)
    );

    always #5 clk_in = ~clk_in;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Model of the ring, kept as host-side shadow memory plus plain counters.
    logic [63:0] shadow [NC*QWS];
    logic [63:0] acc_log [$];
    int acc_total = 0;
    int m_rd = 0, m_wr = 0, m_qw = 0, m_sent = 0;
    bit m_clr = 0;
    int fv_cyc = -1, strobe_cyc = 0, cs_cyc = 0, ce_cyc = 0;

    bit          prev_ok = 0, prev_valid = 0, prev_ready = 0, prev_soft = 0;
    bit          prev_req = 0, prev_ack = 0;
    logic [63:0] prev_data = '0;
    logic [31:0] prev_mdata = '0;
    int          prev_rd = 0;

    int ready_mode = 0;   // 0: always ready, 1: random 50%
    bit ack_auto = 0;
    bit ack_force = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk_in) cyc++;

    always @(posedge clk_in) begin
        #2;
        c2fReady_in = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        mtrAck_in   = ack_force ||
                      (ack_auto && mtrReq_out && !mtrAck_in && ($urandom_range(0, 2) == 0));
    end

    always @(negedge clk_in) begin
        if (!rstn) begin
            m_rd = 0; m_wr = 0; m_qw = 0; m_sent = 0; m_clr = 0;
            prev_ok = 0; prev_rd = 0;
        end else begin
            chk("rdptr", 64'(rdPtr_out), 64'(m_rd));
            if (c2fValid_out) begin
                if (fv_cyc < 0) fv_cyc = cyc;
                chk("valid_when_nonempty", 64'(m_rd != m_wr), 64'd1);
            end
            if (prev_ok && prev_valid && !prev_ready && !prev_soft) begin
                chk("stall_valid_hold", 64'(c2fValid_out), 64'd1);
                chk("stall_data_hold", c2fData_out, prev_data);
            end
            if (prev_ok && prev_req && !prev_ack) begin
                chk("mtr_req_hold", 64'(mtrReq_out), 64'd1);
                chk("mtr_data_hold", 64'(mtrData_out), 64'(prev_mdata));
            end
            if (mtrReq_out && (!prev_ok || !prev_req || mtrData_out != prev_mdata))
                chk("mtr_req_value", 64'(mtrData_out), 64'(prev_rd));
            if (mtrReq_out && (!prev_ok || !prev_req))
                chk("mtr_req_needed", 64'(prev_rd != m_sent), 64'd1);

            if (c2fValid_out && c2fReady_in && !softReset_in) begin
                chk("stream_data", c2fData_out, shadow[m_rd*QWS + m_qw]);
                acc_log.push_back(c2fData_out);
                acc_total++;
                if (m_qw == 0) cs_cyc = cyc;
                if (m_qw == QWS-1) ce_cyc = cyc;
                m_qw++;
                if (m_qw == QWS) begin
                    m_qw = 0;
                    m_rd = (m_rd + 1) % NC;
                end
            end
            if (mtrReq_out && mtrAck_in) begin
                m_sent = m_clr ? 0 : int'(mtrData_out);
                m_clr  = 0;
            end
            if (softReset_in) begin
                m_rd = 0; m_wr = 0; m_qw = 0;
                if (mtrReq_out && !mtrAck_in) m_clr = 1;
                else m_sent = 0;
            end else if (wrPtrValid_in) begin
                m_wr = int'(wrPtr_in);
            end

            prev_ok    = 1;
            prev_valid = c2fValid_out;
            prev_ready = c2fReady_in;
            prev_soft  = softReset_in;
            prev_data  = c2fData_out;
            prev_req   = mtrReq_out;
            prev_ack   = mtrAck_in;
            prev_mdata = mtrData_out;
            prev_rd    = int'(rdPtr_out);
        end
    end

    function automatic logic [63:0] seq64(input int k);
        return {32'hC0DE0000 + 32'(k), ~32'(k)};
    endfunction

    task automatic write_chunk(input int c, input bit rnd);
        for (int k = 0; k < QWS; k++) begin
            @(posedge clk_in); #1;
            ramWrEnable_in = 1'b1;
            ramWrAddr_in   = AW'(c*QWS + k);
            ramWrData_in   = rnd ? {$urandom, $urandom} : seq64(k);
            shadow[c*QWS + k] = ramWrData_in;
        end
        @(posedge clk_in); #1;
        ramWrEnable_in = 1'b0;
    endtask

    task automatic set_wrptr(input int p);
        @(posedge clk_in); #1;
        wrPtrValid_in = 1'b1;
        wrPtr_in      = PTR_W'(p);
        strobe_cyc    = cyc;
        @(posedge clk_in); #1;
        wrPtrValid_in = 1'b0;
    endtask

    task automatic pulse_soft();
        @(posedge clk_in); #1;
        softReset_in = 1'b1;
        @(posedge clk_in); #1;
        softReset_in = 1'b0;
    endtask

    task automatic pulse_ack();
        @(posedge clk_in); #1;
        ack_force = 1'b1;
        @(posedge clk_in); #1;
        ack_force = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        @(negedge clk_in);
        while (!(m_rd == m_wr && !c2fValid_out) && n < budget) begin
            @(negedge clk_in);
            n++;
        end
        chk("drain_timeout", 64'(n < budget), 64'd1);
    endtask

    task automatic wait_req(input int budget);
        int n = 0;
        @(negedge clk_in);
        while (!mtrReq_out && n < budget) begin
            @(negedge clk_in);
            n++;
        end
        chk("mtr_req_timeout", 64'(mtrReq_out), 64'd1);
    endtask

    task automatic wait_qw(input int th, input int budget);
        int n = 0;
        while (m_qw < th && n < budget) begin
            @(posedge clk_in); #1;
            n++;
        end
        chk("qw_progress_timeout", 64'(n < budget), 64'd1);
    endtask

    task automatic quiet(input int n, input string name);
        int seen = 0;
        repeat (n) begin
            @(negedge clk_in);
            if (mtrReq_out) seen++;
        end
        chk(name, 64'(seen), 64'd0);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_valid"}, 64'(c2fValid_out), 64'd0);
        chk({tag, "_data"}, c2fData_out, 64'd0);
        chk({tag, "_rdptr"}, 64'(rdPtr_out), 64'd0);
        chk({tag, "_mtrreq"}, 64'(mtrReq_out), 64'd0);
        chk({tag, "_mtrdata"}, 64'(mtrData_out), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int seen;
        rstn = 1'b0;
        ramWrEnable_in = 1'b0; ramWrAddr_in = '0; ramWrData_in = '0;
        wrPtrValid_in = 1'b0; wrPtr_in = '0; softReset_in = 1'b0;
        c2fReady_in = 1'b1; mtrAck_in = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        chk_outputs_zero("reset");
        rstn = 1'b1;
        repeat (2) @(posedge clk_in);

        // 1: single sequential chunk, full-rate stream, one metrics request
        write_chunk(0, 0);
        fv_cyc = -1;
        set_wrptr(1);
        wait_drain(500);
        chk("first_valid_latency", 64'(fv_cyc >= 0 && (fv_cyc - strobe_cyc) <= 4), 64'd1);
        chk("chunk_back_to_back", 64'(ce_cyc - cs_cyc), 64'd63);
        chk("qw5_literal", acc_log[5], 64'hC0DE0005_FFFFFFFA);
        chk("qw63_literal", acc_log[63], 64'hC0DE003F_FFFFFFC0);
        chk("t1_count", 64'(acc_total), 64'd64);
        chk("t1_rdptr", 64'(rdPtr_out), 64'd1);
        wait_req(100);
        chk("t1_mtr_data", 64'(mtrData_out), 64'd1);
        pulse_ack();
        quiet(30, "t1_no_more_req");

        // 2: three random chunks, random ready, auto-acked metrics
        @(posedge clk_in); #3 rstn = 1'b0;
        repeat (2) @(posedge clk_in);
        #3 rstn = 1'b1;
        for (int c = 0; c < 3; c++) write_chunk(c, 1);
        ack_auto = 1;
        ready_mode = 1;
        set_wrptr(3);
        wait_drain(3000);
        chk("t2_count", 64'(acc_total), 64'd256);
        chk("t2_rdptr", 64'(rdPtr_out), 64'd3);
        repeat (40) @(negedge clk_in);
        chk("t2_mtr_req_idle", 64'(mtrReq_out), 64'd0);
        chk("t2_mtr_final", 64'(mtrData_out), 64'd3);
        chk("t2_mtr_sent", 64'(m_sent), 64'd3);

        // 3: idle soft reset, then five chunks around the ring
        ready_mode = 0;
        pulse_soft();
        quiet(20, "t3_no_req_after_soft");
        chk("t3_rdptr_cleared", 64'(rdPtr_out), 64'd0);
        for (int i = 0; i < 5; i++) begin
            write_chunk(i % NC, 1);
            set_wrptr((i + 1) % NC);
            wait_drain(500);
            chk("t3_rdptr_seq", 64'(rdPtr_out), 64'((i + 1) % NC));
        end
        chk("t3_count", 64'(acc_total), 64'd576);
        repeat (40) @(negedge clk_in);

        // 4: ack withheld across two chunks -> coalesced re-request
        ack_auto = 0;
        chk("t4_idle_before", 64'(mtrReq_out), 64'd0);
        pulse_ack();
        quiet(10, "t4_stray_ack_ignored");
        write_chunk(1, 1);
        write_chunk(2, 1);
        set_wrptr(3);
        wait_drain(800);
        repeat (3) @(negedge clk_in);
        chk("t4_req_held", 64'(mtrReq_out), 64'd1);
        chk("t4_req_data_first", 64'(mtrData_out), 64'd2);
        pulse_ack();
        @(negedge clk_in);
        chk("t4_rereq", 64'(mtrReq_out), 64'd1);
        chk("t4_rereq_data", 64'(mtrData_out), 64'd3);
        pulse_ack();
        quiet(20, "t4_quiet_after_ack");

        // 5: soft reset mid-chunk, then restart from RAM chunk 0
        ack_auto = 1;
        write_chunk(3, 1);
        set_wrptr(0);
        wait_qw(21, 300);
        pulse_soft();
        @(negedge clk_in);
        chk("t5_valid_dropped", 64'(c2fValid_out), 64'd0);
        chk("t5_rdptr_zero", 64'(rdPtr_out), 64'd0);
        quiet(20, "t5_no_req_after_soft");
        write_chunk(0, 1);
        idx = acc_total;
        set_wrptr(1);
        wait_drain(500);
        chk("t5_restart_qw0", acc_log[idx], shadow[0]);
        chk("t5_rdptr", 64'(rdPtr_out), 64'd1);
        repeat (40) @(negedge clk_in);

        // 6: async reset mid-stream with a metrics request pending
        ack_auto = 0;
        ready_mode = 1;
        write_chunk(1, 1);
        set_wrptr(2);
        wait_drain(1000);
        wait_req(50);
        chk("t6_pending_data", 64'(mtrData_out), 64'd2);
        write_chunk(2, 1);
        set_wrptr(3);
        wait_qw(10, 300);
        @(posedge clk_in); #3 rstn = 1'b0;
        #1;
        chk_outputs_zero("t6_async");
        repeat (2) @(posedge clk_in);
        #3 rstn = 1'b1;
        seen = 0;
        repeat (20) begin
            @(negedge clk_in);
            if (mtrReq_out || c2fValid_out) seen++;
        end
        chk("t6_quiet_after_reset", 64'(seen), 64'd0);
        ack_auto = 1;
        write_chunk(0, 1);
        set_wrptr(1);
        wait_drain(1000);
        chk("t6_rdptr", 64'(rdPtr_out), 64'd1);
        repeat (20) @(negedge clk_in);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
